pc_gen_unit: RTL and testbench
==============================

PC_GEN_UNIT -- requirements
Module: pc_gen_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC/data width.
REQ-002 SHALL have parameter RESET_VEC, default 64'h8000_0000, first fetch address.
REQ-003 SHALL have parameter TRAP_VEC, default 64'h8000_0000, ebreak/misalign target.
REQ-004 SHALL have parameter CNT_W, default 32, redirect counter width.
REQ-005 SHALL have ports, one per line:
 clk  in  1  clock; single clock domain
 rst  in  1  synchronous, active-high reset
 stall_i  in  1  hold PC and defer redirects
 fetch_ready_i  in  1  fetch stage accepts pc_o
 fetch_valid_o  out  1  pc_o is a valid fetch request
 pc_o  out  XLEN  current fetch PC
 br_i  in  1  conditional branch resolved taken
 jal_i  in  1  jal resolved
 jalr_i  in  1  jalr resolved
 ebreak_i  in  1  ebreak/trap request
 ex_pc_i  in  XLEN  PC of resolving instruction
 imm_i  in  XLEN  sign-extended immediate
 rs1_i  in  XLEN  jalr base register value
 flush_o  out  1  one-cycle pulse: younger instructions invalid
 misalign_o  out  1  one-cycle pulse: target not 4-byte aligned
 redirect_cnt_o  out  CNT_W  applied-redirect count

Function
REQ-006 SHALL implement FSM states BOOT, RUN, PEND.
REQ-007 BOOT: pc_o=RESET_VEC, fetch_valid_o=0; next cycle -> RUN unconditionally.
REQ-008 RUN: fetch_valid_o=1; on fetch_valid_o&fetch_ready_i and no redirect, pc_o <= pc_o+4 (mod 2^XLEN).
REQ-009 Redirect source priority: ebreak_i > jalr_i > jal_i > br_i; lower sources ignored same cycle.
REQ-010 Targets: ebreak -> TRAP_VEC; jalr -> (rs1_i+imm_i)&~1; jal/br -> ex_pc_i+imm_i; all XLEN, wrap modulo 2^XLEN.
REQ-011 Target with bit[1]=1 (after jalr LSB clear) SHALL be replaced by TRAP_VEC and pulse misalign_o with the redirect.
REQ-012 Redirect in RUN with stall_i=0: pc_o <= target next cycle regardless of fetch_ready_i; flush_o=1 in the request cycle.
REQ-013 Redirect with stall_i=1: latch target in pending register, -> PEND; pc_o unchanged, flush_o=0.
REQ-014 PEND: fetch_valid_o=0; pending target replaced only by a new ebreak_i (or misaligned target); other redirects ignored.
REQ-015 PEND with stall_i=0: pc_o <= pending target, flush_o=1 that cycle, -> RUN.
REQ-016 stall_i=1 in RUN with no redirect: pc_o, fetch_valid_o held; no increment even if fetch_ready_i=1.
REQ-017 misalign_o pulses in the cycle the misaligned redirect is detected, including when deferred.
REQ-018 redirect_cnt_o increments by 1 per applied redirect (cycle flush_o=1); saturates at all-ones.
REQ-019 Outputs flush_o, misalign_o SHALL be combinational from current inputs/state; pc_o, fetch_valid_o, counter registered.

Reset
REQ-020 rst sampled on clk rising edge: state=BOOT, pc_o=RESET_VEC, pending cleared, redirect_cnt_o=0.
REQ-021 During rst: fetch_valid_o=0, flush_o=0, misalign_o=0.
REQ-022 rst asserted in PEND discards the pending target; no flush issued.

Structure
REQ-023 FSM state encoding, RESET_VEC/TRAP_VEC defaults and ILEN (4) SHALL live in the shared rvseed defines package.
REQ-024 Priority select + target compute + alignment check SHALL be sub-module pc_redirect_arb (combinational); FSM/registers in pc_gen_unit.

Verification
REQ-025 Reset release, fetch_ready_i=1 for 3 cycles -> pc_o 8000_0000 (BOOT, valid=0), 8000_0000, 8000_0004, 8000_0008.
REQ-026 jal_i=1 and br_i=1 same cycle, ex_pc_i=8000_0010, imm_i=0x20 -> flush_o=1, next pc_o=8000_0030, cnt=1.
REQ-027 jalr_i, rs1_i=8000_0101, imm_i=2 -> target 8000_0102, misalign_o=1, next pc_o=TRAP_VEC.
REQ-028 stall_i=1 with br_i target 8000_0040, then ebreak_i while stalled, release -> pc_o=TRAP_VEC, single flush, cnt+1.
REQ-029 pc_o=FFFF_FFFF_FFFF_FFFC, handshake -> pc_o wraps to 0; counter forced to all-ones + redirect -> stays all-ones.

Source files
------------

// File: rtl/rvseed_pkg.sv
// Shared rvseed definitions: PC generator FSM encoding, default fetch/trap
// vectors and the fixed instruction length.
package rvseed_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  localparam logic [63:0] RVSEED_RESET_VEC = 64'h8000_0000;
  localparam logic [63:0] RVSEED_TRAP_VEC  = 64'h8000_0000;
  localparam int unsigned ILEN             = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbitration: picks the highest-priority redirect source, computes
// its target and swaps a misaligned target for the trap vector.
module pc_redirect_arb
  import rvseed_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(RVSEED_TRAP_VEC)
) (
  input  logic            br_i,
  input  logic            jal_i,
  input  logic            jalr_i,
  input  logic            ebreak_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic            redirect_o,
  output logic            ebreak_sel_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] raw_target;

  // Priority ebreak > jalr > jal/br; jal and br share the pc-relative form.
  always_comb begin
    jalr_sum   = rs1_i + imm_i;
    raw_target = ex_pc_i + imm_i;
    if (ebreak_i) begin
      raw_target = TRAP_VEC;
    end else if (jalr_i) begin
      raw_target = {jalr_sum[XLEN-1:1], 1'b0};
    end
    redirect_o   = br_i | jal_i | jalr_i | ebreak_i;
    ebreak_sel_o = ebreak_i;
    misalign_o   = redirect_o & ~ebreak_i & raw_target[1];
    target_o     = misalign_o ? TRAP_VEC : raw_target;
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC generator: boots at the reset vector, steps by ILEN on accepted
// fetches and applies (or defers while stalled) branch/jump/trap redirects.
module pc_gen_unit
  import rvseed_pkg::*;
#(
  parameter int              XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RVSEED_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(RVSEED_TRAP_VEC),
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [XLEN-1:0]  pc_o,
  input  logic             br_i,
  input  logic             jal_i,
  input  logic             jalr_i,
  input  logic             ebreak_i,
  input  logic [XLEN-1:0]  ex_pc_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [XLEN-1:0]  rs1_i,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [1:0]       state_o
);

  pc_state_e        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_c, flush_c, misalign_c, replace_c;
  logic [XLEN-1:0]  pend_tgt;

  logic             arb_redirect, arb_ebreak, arb_misalign;
  logic [XLEN-1:0]  arb_target;

  pc_redirect_arb #(
    .XLEN     (XLEN),
    .TRAP_VEC (TRAP_VEC)
  ) u_arb (
    .br_i         (br_i),
    .jal_i        (jal_i),
    .jalr_i       (jalr_i),
    .ebreak_i     (ebreak_i),
    .ex_pc_i      (ex_pc_i),
    .imm_i        (imm_i),
    .rs1_i        (rs1_i),
    .redirect_o   (arb_redirect),
    .ebreak_sel_o (arb_ebreak),
    .misalign_o   (arb_misalign),
    .target_o     (arb_target)
  );

  // Handshake: a fetch of pc_o is accepted in a cycle where fetch_valid_o and
  // fetch_ready_i are both high; pc_o holds until accepted or redirected.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    valid_c    = 1'b0;
    flush_c    = 1'b0;
    misalign_c = 1'b0;
    replace_c  = 1'b0;
    pend_tgt   = pend_q;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        valid_c    = 1'b1;
        misalign_c = arb_misalign;
        if (arb_redirect) begin
          if (!stall_i) begin
            pc_d    = arb_target;
            flush_c = 1'b1;
          end else begin
            pend_d  = arb_target;
            state_d = ST_PEND;
          end
        end else if (!stall_i && fetch_ready_i) begin
          pc_d = pc_q + XLEN'(ILEN);
        end
      end
      ST_PEND: begin
        // Only a trap-class redirect may overwrite the deferred target.
        misalign_c = arb_misalign;
        replace_c  = arb_ebreak | arb_misalign;
        pend_tgt   = replace_c ? arb_target : pend_q;
        pend_d     = pend_tgt;
        if (!stall_i) begin
          pc_d    = pend_tgt;
          flush_c = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (flush_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign fetch_valid_o  = valid_c & ~rst;
  assign flush_o        = flush_c & ~rst;
  assign misalign_o     = misalign_c & ~rst;
  assign pc_o           = pc_q;
  assign redirect_cnt_o = cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench for pc_gen_unit: a cycle-by-cycle vector table plus
// hand-written wrap, saturation and reset-in-flight sequences.
module tb_pc_gen_unit;
  import rvseed_pkg::*;

  localparam logic [63:0] B = 64'h8000_0000;
  localparam logic [63:0] T = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, ready, br, jal, jalr, ebreak;
  logic [63:0] ex_pc, imm, rs1;

  logic        valid, flush, mis;
  logic [63:0] pc;
  logic [31:0] cnt;
  logic [1:0]  state_m;

  logic        valid_s, flush_s, mis_s;
  logic [63:0] pc_s;
  logic [2:0]  cnt_s;
  logic [1:0]  state_s;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    string       nm;
    logic        s, rdy, b, j, jr, e;
    logic [63:0] ex, im, r1, e_pc;
    logic [1:0]  e_st;
    logic        e_v, e_f, e_m;
    int          e_cnt;
  } vec_t;
  vec_t vq[$];

  pc_gen_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(valid), .pc_o(pc), .br_i(br), .jal_i(jal), .jalr_i(jalr),
    .ebreak_i(ebreak), .ex_pc_i(ex_pc), .imm_i(imm), .rs1_i(rs1),
    .flush_o(flush), .misalign_o(mis), .redirect_cnt_o(cnt), .state_o(state_m)
  );

  pc_gen_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall_i(stall), .fetch_ready_i(ready),
    .fetch_valid_o(valid_s), .pc_o(pc_s), .br_i(br), .jal_i(jal), .jalr_i(jalr),
    .ebreak_i(ebreak), .ex_pc_i(ex_pc), .imm_i(imm), .rs1_i(rs1),
    .flush_o(flush_s), .misalign_o(mis_s), .redirect_cnt_o(cnt_s), .state_o(state_s)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: bench did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // driver tasks
  task automatic drv(input logic r, s, rdy, b, j, jr, e,
                     input logic [63:0] ex, im, r1);
    rst = r; stall = s; ready = rdy; br = b; jal = j; jalr = jr; ebreak = e;
    ex_pc = ex; imm = im; rs1 = r1;
  endtask

  task automatic add(input string nm, input logic s, rdy, b, j, jr, e,
                     input logic [63:0] ex, im, r1, e_pc, input logic [1:0] e_st,
                     input logic e_v, e_f, e_m, input int e_cnt);
    vec_t v;
    v.nm = nm; v.s = s; v.rdy = rdy; v.b = b; v.j = j; v.jr = jr; v.e = e;
    v.ex = ex; v.im = im; v.r1 = r1; v.e_pc = e_pc; v.e_st = e_st;
    v.e_v = e_v; v.e_f = e_f; v.e_m = e_m; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  // scoreboard
  task automatic chk(input string nm, input string what, input logic [63:0] got, exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, what, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [63:0] e_pc, input logic [1:0] e_st,
                         input logic e_v, e_f, e_m, input int e_cnt);
    int e_sat;
    e_sat = (e_cnt > 7) ? 7 : e_cnt;
    chk(nm, "pc", pc, e_pc);
    chk(nm, "state", 64'(state_m), 64'(e_st));
    chk(nm, "valid", 64'(valid), 64'(e_v));
    chk(nm, "flush", 64'(flush), 64'(e_f));
    chk(nm, "misalign", 64'(mis), 64'(e_m));
    chk(nm, "cnt", 64'(cnt), 64'(e_cnt));
    chk(nm, "sat_cnt", 64'(cnt_s), 64'(e_sat));
    chk(nm, "sat_pc", pc_s, e_pc);
    chk(nm, "sat_ctl", 64'({state_s, valid_s, flush_s, mis_s}),
        64'({e_st, e_v, e_f, e_m}));
  endtask

  task automatic step_hand(input string nm, input logic r, s, rdy, b, j, jr, e,
                           input logic [63:0] ex, im, r1, input logic [1:0] e_st,
                           input logic e_v, e_f, e_m, input int e_cnt);
    @(posedge clk); #1;
    drv(r, s, rdy, b, j, jr, e, ex, im, r1);
    @(negedge clk);
    chk_out(nm, exp_q.pop_front(), e_st, e_v, e_f, e_m, e_cnt);
  endtask

  initial begin
    //     name      s rdy b j jr e  ex_pc      imm     rs1        exp_pc    st  v f m cnt
    add("boot",      0,1, 0,0,0,0, 0,         0,      0,         B,        ST_BOOT,0,0,0,0);
    add("run0",      0,1, 0,0,0,0, 0,         0,      0,         B,        ST_RUN, 1,0,0,0);
    add("run4",      0,1, 0,0,0,0, 0,         0,      0,         B+4,      ST_RUN, 1,0,0,0);
    add("run8",      0,1, 0,0,0,0, 0,         0,      0,         B+8,      ST_RUN, 1,0,0,0);
    add("noready",   0,0, 0,0,0,0, 0,         0,      0,         B+'hc,    ST_RUN, 1,0,0,0);
    add("stallhold", 1,1, 0,0,0,0, 0,         0,      0,         B+'hc,    ST_RUN, 1,0,0,0);
    add("jal_br",    0,0, 1,1,0,0, B+'h10,    'h20,   0,         B+'hc,    ST_RUN, 1,1,0,0);
    add("after_jal", 0,1, 0,0,0,0, 0,         0,      0,         B+'h30,   ST_RUN, 1,0,0,1);
    add("jalr_mis",  0,1, 0,1,1,0, 0,         2,      B+'h101,   B+'h34,   ST_RUN, 1,1,1,1);
    add("jalr_ok",   0,1, 1,0,1,0, 0,         3,      B+'h201,   T,        ST_RUN, 1,1,0,2);
    add("ebrk_prio", 0,1, 0,0,1,1, 0,         0,      B+2,       B+'h204,  ST_RUN, 1,1,0,3);
    add("post_trap", 0,1, 0,0,0,0, 0,         0,      0,         T,        ST_RUN, 1,0,0,4);
    add("defer_br",  1,1, 1,0,0,0, B+'h30,    'h10,   0,         B+4,      ST_RUN, 1,0,0,4);
    add("pend_jal",  1,1, 0,1,0,0, B+'h100,   0,      0,         B+4,      ST_PEND,0,0,0,4);
    add("pend_ebrk", 1,1, 0,0,0,1, 0,         0,      0,         B+4,      ST_PEND,0,0,0,4);
    add("pend_rel",  0,1, 0,0,0,0, 0,         0,      0,         B+4,      ST_PEND,0,1,0,4);
    add("at_trap",   0,1, 0,0,0,0, 0,         0,      0,         T,        ST_RUN, 1,0,0,5);
    add("defer_jal", 1,1, 0,1,0,0, B+'h40,    'h10,   0,         B+4,      ST_RUN, 1,0,0,5);
    add("pend_mis",  1,1, 0,0,1,0, 0,         0,      B+6,       B+4,      ST_PEND,0,0,1,5);
    add("pend_rel2", 0,1, 0,0,0,0, 0,         0,      0,         B+4,      ST_PEND,0,1,0,5);
    add("at_trap2",  0,0, 0,0,0,0, 0,         0,      0,         T,        ST_RUN, 1,0,0,6);
    add("defer_j2",  1,1, 0,1,0,0, B+'h50,    'h10,   0,         T,        ST_RUN, 1,0,0,6);
    add("pend_rel3", 0,1, 0,0,0,0, 0,         0,      0,         T,        ST_PEND,0,1,0,6);
    add("at_60",     0,1, 0,0,0,0, 0,         0,      0,         B+'h60,   ST_RUN, 1,0,0,7);
    add("defer_mis", 1,1, 0,0,1,0, 0,         0,      B+'ha,     B+'h64,   ST_RUN, 1,0,1,7);
    add("pend_rel4", 0,1, 0,0,0,0, 0,         0,      0,         B+'h64,   ST_PEND,0,1,0,7);
    add("sat_reach", 0,0, 0,0,0,0, 0,         0,      0,         T,        ST_RUN, 1,0,0,8);

    // reset: redirect requests present but must not flush
    drv(1, 0, 1, 1, 1, 0, 1, 0, 'h40, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("reset", B, ST_BOOT, 0, 0, 0, 0);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drv(0, vq[i].s, vq[i].rdy, vq[i].b, vq[i].j, vq[i].jr, vq[i].e,
          vq[i].ex, vq[i].im, vq[i].r1);
      @(negedge clk);
      chk_out(vq[i].nm, vq[i].e_pc, vq[i].e_st, vq[i].e_v, vq[i].e_f, vq[i].e_m, vq[i].e_cnt);
    end

    // pc wrap through the handshake and through target arithmetic
    exp_q.push_back(T);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h14);
    step_hand("to_top",   0,0,1, 0,1,0,0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, ST_RUN, 1,1,0,8);
    step_hand("at_top",   0,0,1, 0,0,0,0, 0, 0, 0,                    ST_RUN, 1,0,0,9);
    step_hand("wrapped",  0,0,1, 0,0,0,0, 0, 0, 0,                    ST_RUN, 1,0,0,9);
    step_hand("tgt_wrap", 0,0,0, 0,1,0,0, 64'hFFFF_FFFF_FFFF_FFF0, 'h24, 0, ST_RUN, 1,1,0,9);
    step_hand("at_14",    0,0,0, 0,0,0,0, 0, 0, 0,                    ST_RUN, 1,0,0,10);

    // reset while running with a misaligned jalr pending on the inputs
    exp_q.push_back(64'h14);
    exp_q.push_back(B);
    exp_q.push_back(B);
    step_hand("rst_run",  1,0,1, 0,1,1,0, 0, 0, 2, ST_RUN,  0,0,0,10);
    step_hand("rst_done", 1,0,1, 0,0,0,0, 0, 0, 0, ST_BOOT, 0,0,0,0);
    step_hand("reboot",   0,0,1, 0,0,0,0, 0, 0, 0, ST_BOOT, 0,0,0,0);

    // reset in PEND discards the deferred target
    exp_q.push_back(B);
    exp_q.push_back(B);
    exp_q.push_back(B);
    exp_q.push_back(B);
    exp_q.push_back(B + 4);
    step_hand("defer_rst", 0,1,1, 1,0,0,0, B, 'h80, 0, ST_RUN,  1,0,0,0);
    step_hand("rst_pend",  1,0,1, 0,0,0,0, 0, 0, 0,    ST_PEND, 0,0,0,0);
    step_hand("boot2",     0,0,1, 0,0,0,0, 0, 0, 0,    ST_BOOT, 0,0,0,0);
    step_hand("run2",      0,0,1, 0,0,0,0, 0, 0, 0,    ST_RUN,  1,0,0,0);
    step_hand("no_stale",  0,0,0, 0,0,0,0, 0, 0, 0,    ST_RUN,  1,0,0,0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
